// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch / data) arbiter in front of a single RAM port.
// Optional macro ARB_RR_EN selects round-robin arbitration; otherwise data always has priority.
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iren,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dren,
  input  logic              dwen,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] IACC = 2'd1;
  localparam logic [1:0] DACC = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       dreq;
  logic       prefer_i;

  assign dreq = dren | dwen;

`ifdef ARB_RR_EN
  // Requester of the most recent completed access: 0 = instruction, 1 = data.
  logic last_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b0;
    end else if (state == IACC && iren && ram_ready) begin
      last_grant <= 1'b0;
    end else if (state == DACC && dreq && ram_ready) begin
      last_grant <= 1'b1;
    end
  end

  assign prefer_i = last_grant;
`else
  assign prefer_i = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dreq && !(iren && prefer_i)) begin
          state_nxt = DACC;
        end else if (iren) begin
          state_nxt = IACC;
        end
      end
      // A dropped request aborts the access just like a completion does.
      IACC: if (!iren || ram_ready) state_nxt = IDLE;
      DACC: if (!dreq || ram_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Strobes follow the live request so an abort drops them in the same cycle.
  always_comb begin
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    case (state)
      IACC: begin
        ram_ren  = iren;
        ram_addr = iaddr;
      end
      DACC: begin
        ram_wen   = dwen;
        ram_ren   = dren & ~dwen;
        ram_addr  = daddr;
        ram_store = dstore;
      end
      default: ;
    endcase
  end

  assign iwait = iren & ~((state == IACC) & ram_ready);
  assign dwait = dreq & ~((state == DACC) & ram_ready);
  assign iload = ram_load;
  assign dload = ram_load;

endmodule

`default_nettype wire
